// File: rtl/taxi_rst_seq_pkg.sv
// Shared types and constants for the multi-stage reset sequencer.
package taxi_rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_HOLD      = 2'd1,
      ST_RELEASE   = 2'd2,
      ST_RUN       = 2'd3
   } state_e;

   localparam int FAULT_W = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/taxi_rst_seq_if.sv
// Lock/request inputs and sequenced reset outputs of the reset sequencer.
interface taxi_rst_seq_if #(
   parameter int STAGES = 3
);

   logic                                 lock;
   logic                                 sw_rst;
   logic [STAGES-1:0]                    rst_out;
   logic                                 done;
   logic [taxi_rst_seq_pkg::FAULT_W-1:0] fault_cnt;

   modport master (
      output lock,
      output sw_rst,
      input  rst_out,
      input  done,
      input  fault_cnt
   );

   modport slave (
      input  lock,
      input  sw_rst,
      output rst_out,
      output done,
      output fault_cnt
   );

endinterface

// File: rtl/taxi_rst_seq.sv
// Reset sequencer: qualifies lock, waits a hold-off, then releases resets in order;
// lock loss or a software request re-asserts every reset on the next edge.
module taxi_rst_seq
   import taxi_rst_seq_pkg::*;
#(
   parameter int STAGES      = 3,
   parameter int LOCK_FILTER = 8,
   parameter int HOLD_CYCLES = 256,
   parameter int STAGE_GAP   = 16
) (
   input  logic           clk,
   input  logic           rst,
   taxi_rst_seq_if.slave  bus
);

   localparam int MAX_C = max3(LOCK_FILTER, HOLD_CYCLES, STAGE_GAP);
   localparam int CNT_W = $clog2(MAX_C + 1);
   localparam int IDX_W = $clog2(STAGES + 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [STAGES-1:0]    rst_out_q, rst_out_d;
   logic                 done_q, done_d;
   logic [FAULT_W-1:0]   fault_cnt_q, fault_cnt_d;
   logic                 abort;

   // The shared counter idles at zero; the first counted cycle of a phase loads
   // target-1 and the phase completes on the cycle that sees it at one.
   function automatic logic cnt_fire(input logic [CNT_W-1:0] c, input int target);
      return (c == CNT_W'(1)) || ((c == '0) && (target == 1));
   endfunction

   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c, input int target);
      if (cnt_fire(c, target)) begin
         return '0;
      end else if (c == '0) begin
         return CNT_W'(target - 1);
      end else begin
         return c - CNT_W'(1);
      end
   endfunction

   assign abort = !bus.lock || bus.sw_rst;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      rst_out_d   = rst_out_q;
      done_d      = done_q;
      fault_cnt_d = fault_cnt_q;

      if (state_q != ST_WAIT_LOCK && abort) begin
         state_d   = ST_WAIT_LOCK;
         cnt_d     = '0;
         idx_d     = '0;
         rst_out_d = '1;
         done_d    = 1'b0;
         if (!bus.lock && fault_cnt_q != '1) begin
            fault_cnt_d = fault_cnt_q + FAULT_W'(1);
         end
      end else begin
         case (state_q)
            ST_WAIT_LOCK: begin
               if (bus.lock && !bus.sw_rst) begin
                  if (cnt_fire(cnt_q, LOCK_FILTER)) begin
                     state_d = ST_HOLD;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_next(cnt_q, LOCK_FILTER);
                  end
               end else begin
                  cnt_d = '0;
               end
            end

            ST_HOLD: begin
               if (cnt_fire(cnt_q, HOLD_CYCLES)) begin
                  cnt_d        = '0;
                  rst_out_d[0] = 1'b0;
                  if (STAGES == 1) begin
                     done_d  = 1'b1;
                     state_d = ST_RUN;
                  end else begin
                     idx_d   = IDX_W'(1);
                     state_d = ST_RELEASE;
                  end
               end else begin
                  cnt_d = cnt_next(cnt_q, HOLD_CYCLES);
               end
            end

            ST_RELEASE: begin
               if (cnt_fire(cnt_q, STAGE_GAP)) begin
                  cnt_d = '0;
                  for (int i = 0; i < STAGES; i++) begin
                     if (idx_q == IDX_W'(i)) begin
                        rst_out_d[i] = 1'b0;
                     end
                  end
                  idx_d = idx_q + IDX_W'(1);
                  if (idx_q == IDX_W'(STAGES - 1)) begin
                     done_d  = 1'b1;
                     state_d = ST_RUN;
                  end
               end else begin
                  cnt_d = cnt_next(cnt_q, STAGE_GAP);
               end
            end

            ST_RUN: begin
               state_d = ST_RUN;
            end

            default: begin
               state_d   = ST_WAIT_LOCK;
               cnt_d     = '0;
               idx_d     = '0;
               rst_out_d = '1;
               done_d    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_WAIT_LOCK;
         cnt_q       <= '0;
         idx_q       <= '0;
         rst_out_q   <= '1;
         done_q      <= 1'b0;
         fault_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         rst_out_q   <= rst_out_d;
         done_q      <= done_d;
         fault_cnt_q <= fault_cnt_d;
      end
   end

   assign bus.rst_out   = rst_out_q;
   assign bus.done      = done_q;
   assign bus.fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_taxi_rst_seq.sv
// Bench for taxi_rst_seq: directed scenarios plus random lock/sw_rst traffic
// checked against a timeline model of the release schedule.
module tb_taxi_rst_seq;

   localparam int STAGES      = 3;
   localparam int LOCK_FILTER = 4;
   localparam int HOLD_CYCLES = 8;
   localparam int STAGE_GAP   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   taxi_rst_seq_if #(.STAGES(STAGES)) bus();

   taxi_rst_seq #(
      .STAGES      (STAGES),
      .LOCK_FILTER (LOCK_FILTER),
      .HOLD_CYCLES (HOLD_CYCLES),
      .STAGE_GAP   (STAGE_GAP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   // Model: count consecutive good-lock cycles; once qualified, track elapsed
   // edges since qualification and derive released stages from the schedule.
   int m_run   = 0;
   bit m_armed = 0;
   int m_e     = 0;
   int m_fault = 0;

   function automatic logic [STAGES-1:0] exp_rst();
      logic [STAGES-1:0] v;
      v = '1;
      if (m_armed)
         for (int i = 0; i < STAGES; i++)
            if (m_e >= HOLD_CYCLES + i * STAGE_GAP) v[i] = 1'b0;
      return v;
   endfunction

   function automatic logic exp_done();
      return m_armed && (m_e >= HOLD_CYCLES + (STAGES - 1) * STAGE_GAP);
   endfunction

   task automatic model_step();
      if (rst) begin
         m_run = 0; m_armed = 0; m_e = 0; m_fault = 0;
      end else if (m_armed) begin
         if (!bus.lock || bus.sw_rst) begin
            if (!bus.lock && m_fault < 255) m_fault++;
            m_armed = 0; m_run = 0; m_e = 0;
         end else if (m_e < 100000) begin
            m_e++;
         end
      end else begin
         if (bus.lock && !bus.sw_rst) begin
            m_run++;
            if (m_run == LOCK_FILTER) begin
               m_armed = 1; m_e = 0; m_run = 0;
            end
         end else begin
            m_run = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset(input logic lk);
      rst = 1'b1; bus.lock = 1'b0; bus.sw_rst = 1'b0;
      tick(); tick();
      rst = 1'b0; bus.lock = lk;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.lock = 1'b0; bus.sw_rst = 1'b0;
      tick(); tick();
      n_checks++;
      if (bus.rst_out !== 3'b111) begin n_fails++; $display("FAIL reset_rst_out got=%b want=111", bus.rst_out); end
      n_checks++;
      if (bus.done !== 1'b0) begin n_fails++; $display("FAIL reset_done got=%b want=0", bus.done); end
      n_checks++;
      if (bus.fault_cnt !== 8'd0) begin n_fails++; $display("FAIL reset_fault got=%0d want=0", bus.fault_cnt); end
   endtask

   task automatic test_basic();
      logic [2:0] want;
      do_reset(1'b1);
      for (int e = 1; e <= 20; e++) begin
         tick();
         want = (e < 12) ? 3'b111 : (e < 14) ? 3'b110 : (e < 16) ? 3'b100 : 3'b000;
         n_checks++;
         if (bus.rst_out !== want || bus.done !== (e >= 16)) begin
            n_fails++;
            $display("FAIL basic_edge%0d got rst_out=%b done=%b want rst_out=%b done=%b", e, bus.rst_out, bus.done, want, e >= 16);
         end
      end
      n_checks++;
      if (bus.fault_cnt !== 8'd0) begin n_fails++; $display("FAIL basic_fault got=%0d want=0", bus.fault_cnt); end
   endtask

   task automatic test_glitch();
      logic [2:0] want;
      do_reset(1'b1);
      for (int e = 1; e <= 24; e++) begin
         bus.lock = (e == 4) ? 1'b0 : 1'b1;
         tick();
         want = (e < 16) ? 3'b111 : (e < 18) ? 3'b110 : (e < 20) ? 3'b100 : 3'b000;
         n_checks++;
         if (bus.rst_out !== want || bus.done !== (e >= 20) || bus.rst_out !== exp_rst()) begin
            n_fails++;
            $display("FAIL glitch_edge%0d got rst_out=%b done=%b want rst_out=%b done=%b", e, bus.rst_out, bus.done, want, e >= 20);
         end
      end
      n_checks++;
      if (bus.fault_cnt !== 8'd0) begin n_fails++; $display("FAIL glitch_fault got=%0d want=0", bus.fault_cnt); end
   endtask

   task automatic test_abort_release();
      int  edges;
      bit  seen;
      do_reset(1'b1);
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         tick();
         if (bus.rst_out === 3'b110) seen = 1;
      end
      n_checks++;
      if (!seen) begin n_fails++; $display("FAIL abort_reach_release got rst_out=%b want=110 within 50 cycles", bus.rst_out); end
      bus.lock = 1'b0;
      tick();
      bus.lock = 1'b1;
      n_checks++;
      if (bus.rst_out !== 3'b111 || bus.done !== 1'b0 || bus.fault_cnt !== 8'd1) begin
         n_fails++;
         $display("FAIL abort_response got rst_out=%b done=%b fault=%0d want 111/0/1", bus.rst_out, bus.done, bus.fault_cnt);
      end
      edges = 0;
      for (int k = 0; k < 40 && !bus.done; k++) begin
         tick();
         edges++;
         n_checks++;
         if (bus.rst_out !== exp_rst() || bus.done !== exp_done() || bus.fault_cnt !== m_fault[7:0]) begin
            n_fails++;
            $display("FAIL abort_resequence got rst_out=%b done=%b fault=%0d want %b/%b/%0d", bus.rst_out, bus.done, bus.fault_cnt, exp_rst(), exp_done(), m_fault);
         end
      end
      n_checks++;
      if (edges !== 16) begin n_fails++; $display("FAIL abort_restart_latency got=%0d want=16", edges); end
   endtask

   task automatic test_sw_rst();
      int edges;
      logic [7:0] f0;
      f0 = bus.fault_cnt;
      bus.sw_rst = 1'b1;
      tick();
      n_checks++;
      if (bus.rst_out !== 3'b111 || bus.done !== 1'b0 || bus.fault_cnt !== f0) begin
         n_fails++;
         $display("FAIL swrst_response got rst_out=%b done=%b fault=%0d want 111/0/%0d", bus.rst_out, bus.done, bus.fault_cnt, f0);
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         n_checks++;
         if (bus.rst_out !== 3'b111) begin n_fails++; $display("FAIL swrst_held got rst_out=%b want=111", bus.rst_out); end
      end
      bus.sw_rst = 1'b0;
      edges = 0;
      for (int k = 0; k < 40 && !bus.done; k++) begin
         tick();
         edges++;
      end
      n_checks++;
      if (edges !== 16) begin n_fails++; $display("FAIL swrst_restart_latency got=%0d want=16", edges); end
      n_checks++;
      if (bus.fault_cnt !== f0) begin n_fails++; $display("FAIL swrst_fault got=%0d want=%0d", bus.fault_cnt, f0); end
   endtask

   task automatic test_saturation();
      bit timeout;
      timeout = 0;
      for (int n = 0; n < 300; n++) begin
         bus.lock = 1'b1;
         for (int k = 0; k < 40 && !bus.done; k++) tick();
         if (!bus.done) timeout = 1;
         bus.lock = 1'b0;
         tick();
      end
      bus.lock = 1'b1;
      n_checks++;
      if (timeout) begin n_fails++; $display("FAIL sat_reach_run got done=0 want done=1 within 40 cycles"); end
      n_checks++;
      if (bus.fault_cnt !== 8'd255 || bus.fault_cnt !== m_fault[7:0]) begin
         n_fails++;
         $display("FAIL sat_fault got=%0d want=255", bus.fault_cnt);
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if (bus.fault_cnt !== 8'd0 || bus.rst_out !== 3'b111 || bus.done !== 1'b0) begin
         n_fails++;
         $display("FAIL sat_reset got fault=%0d rst_out=%b done=%b want 0/111/0", bus.fault_cnt, bus.rst_out, bus.done);
      end
      rst = 1'b0;
   endtask

   task automatic test_rst_mid_hold();
      int edges;
      do_reset(1'b1);
      repeat (6) tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if (bus.rst_out !== 3'b111 || bus.done !== 1'b0 || bus.fault_cnt !== 8'd0) begin
         n_fails++;
         $display("FAIL midhold_reset got rst_out=%b done=%b fault=%0d want 111/0/0", bus.rst_out, bus.done, bus.fault_cnt);
      end
      rst = 1'b0;
      edges = 0;
      for (int k = 0; k < 40 && bus.rst_out[0] !== 1'b0; k++) begin
         tick();
         edges++;
      end
      n_checks++;
      if (edges !== 12) begin n_fails++; $display("FAIL midhold_restart_latency got=%0d want=12", edges); end
   endtask

   task automatic test_random();
      do_reset(1'b1);
      for (int k = 0; k < 3000; k++) begin
         bus.lock   = ($urandom_range(0, 99) < 97);
         bus.sw_rst = ($urandom_range(0, 199) == 0);
         rst        = ($urandom_range(0, 499) == 0);
         tick();
         n_checks++;
         if (bus.rst_out !== exp_rst() || bus.done !== exp_done() || bus.fault_cnt !== m_fault[7:0]) begin
            n_fails++;
            $display("FAIL random_cycle%0d got rst_out=%b done=%b fault=%0d want %b/%b/%0d", k, bus.rst_out, bus.done, bus.fault_cnt, exp_rst(), exp_done(), m_fault);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      bus.lock   = 1'b0;
      bus.sw_rst = 1'b0;
      test_reset();
      test_basic();
      test_glitch();
      test_abort_release();
      test_sw_rst();
      test_saturation();
      test_rst_mid_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/taxi_rst_seq.md
# taxi_rst_seq

Multi-stage reset sequencer that consumes the synchronized reset produced by the reset synchronizer stage and releases an ordered set of downstream resets (e.g. SERDES/PCS, then MAC, then user logic) only after a lock indication has been stable and a hold-off has elapsed. Any loss of lock, or a software reset request, re-asserts every output reset at once. Sits directly after the reset synchronizer in each clock domain of the MAC/PHY datapath.

## Interface

- STAGES, 3, number of sequenced reset outputs (≥1)
- LOCK_FILTER, 8, consecutive cycles lock must be high before hold-off starts (≥1)
- HOLD_CYCLES, 256, hold-off cycles after lock qualified, before stage 0 release (≥1)
- STAGE_GAP, 16, cycles between successive stage releases (≥1)

- clk  input  1  domain clock
- rst  input  1  synchronous, active-high reset; driven by the reset synchronizer output
- lock  input  1  PLL/CDR lock, already synchronous to clk
- sw_rst  input  1  software reset request, level-sensitive
- rst_out  output  STAGES  active-high resets; bit i released after bit i-1
- done  output  1  all stages released
- fault_cnt  output  8  lock-loss event count, saturating at 255

## Operation

- States: WAIT_LOCK, HOLD, RELEASE, RUN.
- rst (highest priority): state WAIT_LOCK, rst_out all 1, done 0, fault_cnt 0, all counters 0.
- WAIT_LOCK: filter counter increments on lock=1 & sw_rst=0, clears otherwise; on the edge sampling the LOCK_FILTER-th consecutive qualifying cycle -> HOLD, counter cleared.
- HOLD: counts cycles; on the HOLD_CYCLES-th cycle -> RELEASE, rst_out[0] cleared on that edge, stage index 1.
- RELEASE: every STAGE_GAP cycles clear rst_out[idx], idx++; clearing rst_out[STAGES-1] sets done and -> RUN. STAGES=1: HOLD goes directly to RUN with done set.
- Abort (HOLD, RELEASE, RUN): lock=0 or sw_rst=1 sampled -> same edge: rst_out all 1, done 0, counters 0, -> WAIT_LOCK.
- fault_cnt increments (saturating) on abort edges where lock=0, regardless of sw_rst; sw_rst alone does not count. lock=0 in WAIT_LOCK does not count.
- rst_out bits never released out of order; once rst_out[i]=0, all lower bits are 0.

## Timing

- Edge 1 = first edge sampling lock=1 in WAIT_LOCK with lock held high thereafter.
- HOLD entered at edge LOCK_FILTER; rst_out[0] low after edge LOCK_FILTER+HOLD_CYCLES.
- rst_out[i] low after edge LOCK_FILTER+HOLD_CYCLES+i·STAGE_GAP; done high on same edge as rst_out[STAGES-1] falls.
- Abort latency: one edge from lock/sw_rst sample to rst_out all 1.
- A single-cycle lock drop in WAIT_LOCK restarts the filter from zero.
- All outputs registered; no combinational path input -> output.
- Counter widths: $clog2(max(LOCK_FILTER,HOLD_CYCLES,STAGE_GAP)+1); index width $clog2(STAGES+1).

## Structure

- Package taxi_rst_seq_pkg: state enum typedef (2-bit), fault_cnt width constant (8).
- Single shared down-counter reused across WAIT_LOCK/HOLD/RELEASE; no sub-module required.

## Test plan

- STAGES=3, LOCK_FILTER=4, HOLD_CYCLES=8, STAGE_GAP=2, rst 1->0, lock held 1 -> rst_out[0] falls edge 12, [1] edge 14, [2] edge 16, done=1 edge 16, fault_cnt=0.
- Same params, lock pulses 1,1,1,0 then steady 1 -> HOLD entry counted from the post-glitch edge; fault_cnt stays 0.
- In RELEASE after rst_out[0]=0, drop lock one cycle -> next edge rst_out=3'b111, done=0, fault_cnt=1, full sequence repeats.
- In RUN assert sw_rst with lock=1 -> rst_out=3'b111 next edge, fault_cnt unchanged; sequence restarts after sw_rst drops.
- Force 300 lock-loss events in RUN -> fault_cnt saturates at 255; then assert rst -> fault_cnt=0, rst_out=3'b111, done=0 next edge.
- Assert rst mid-HOLD with lock=1 -> state WAIT_LOCK, outputs reset, filter restarts from zero after rst deasserts.
